// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller: FSM state encoding and
// width helpers used by the controller and its arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

  function automatic int offset_w(input int words_per_block);
    return (words_per_block > 1) ? $clog2(words_per_block) : 1;
  endfunction

  function automatic int idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, pointer moves past the
// winner whenever a grant is taken.
module rr_arbiter import cache_pkg::*; #(
  parameter int NUM_CH = 2,
  localparam int IDX_W = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_CH]) begin
        found     = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + i) % NUM_CH);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block fill controller shared by several caches: arbitrates misses, streams
// word reads to memory, writes returning words and finally the tag.
module cache_fill_ctrl import cache_pkg::*; #(
  parameter int ADDR_W          = 16,
  parameter int WORD_BYTES      = 2,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int NUM_CH          = 2,
  localparam int OFF_W = offset_w(WORDS_PER_BLOCK)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        miss_detected,
  input  logic [NUM_CH*ADDR_W-1:0] miss_address,
  input  logic                     memory_data_valid,
  output logic                     memory_read_en,
  output logic [ADDR_W-1:0]        memory_address,
  output logic [NUM_CH-1:0]        fsm_busy,
  output logic [NUM_CH-1:0]        write_data_array,
  output logic [NUM_CH-1:0]        write_tag_array,
  output logic [OFF_W-1:0]         fill_word_offset
);

  localparam int IDX_W    = idx_w(NUM_CH);
  localparam int CNT_W    = OFF_W + 1;
  localparam int BLK_BITS = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLK_BITS) - 1);

  fill_state_t       state, state_nxt;
  logic [IDX_W-1:0]  grant_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  req_cnt, resp_cnt;
  logic [NUM_CH-1:0] arb_grant, own;
  logic [IDX_W-1:0]  arb_idx;
  logic [ADDR_W-1:0] req_addr;
  logic              start, resp_fire;

  assign req_addr = miss_address[int'(arb_idx)*ADDR_W +: ADDR_W];

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (miss_detected),
    .advance   (start),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Requests and responses are counted separately so memory may pipeline reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      base_q   <= '0;
      req_cnt  <= '0;
      resp_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant_q  <= arb_idx;
        base_q   <= req_addr & BLK_MASK;
        req_cnt  <= '0;
        resp_cnt <= '0;
      end else begin
        if (memory_read_en) req_cnt  <= req_cnt + CNT_W'(1);
        if (resp_fire)      resp_cnt <= resp_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    start            = 1'b0;
    resp_fire        = 1'b0;
    own              = '0;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = '0;
    write_tag_array  = '0;
    fill_word_offset = '0;
    unique case (state)
      IDLE: begin
        start = |arb_grant;
        // Gated by rst_n so the address bus reads zero while reset is held.
        if (start && rst_n) memory_address = req_addr;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        own[grant_q]              = 1'b1;
        memory_read_en            = req_cnt < FULL;
        memory_address            = base_q + ADDR_W'(req_cnt) * ADDR_W'(WORD_BYTES);
        resp_fire                 = memory_data_valid && (resp_cnt < FULL);
        write_data_array[grant_q] = resp_fire;
        fill_word_offset          = resp_cnt[OFF_W-1:0];
        if (resp_fire && resp_cnt == LAST) state_nxt = TAG;
      end
      TAG: begin
        own[grant_q]             = 1'b1;
        write_tag_array[grant_q] = 1'b1;
        state_nxt                = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    fsm_busy = miss_detected | own;
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: directed scenarios plus randomized
// misses, checked every cycle against a behavioural model of the fill rules.
module tb_cache_fill_ctrl;

  localparam int ADDR_W     = 16;
  localparam int WORD_BYTES = 2;
  localparam int WPB        = 8;
  localparam int NUM_CH     = 2;
  localparam int OFF_W      = 3;
  localparam int BLK_BYTES  = WPB * WORD_BYTES;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_CH-1:0]        miss_detected = '0;
  logic [NUM_CH*ADDR_W-1:0] miss_address = '0;
  logic                     memory_data_valid = 1'b0;
  logic                     memory_read_en;
  logic [ADDR_W-1:0]        memory_address;
  logic [NUM_CH-1:0]        fsm_busy;
  logic [NUM_CH-1:0]        write_data_array;
  logic [NUM_CH-1:0]        write_tag_array;
  logic [OFF_W-1:0]         fill_word_offset;

  always #5 clk = ~clk;

  cache_fill_ctrl #(
    .ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES), .WORDS_PER_BLOCK(WPB), .NUM_CH(NUM_CH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_word_offset  (fill_word_offset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: which channel is being filled, how far along it is.
  bit m_active = 0, m_tag = 0;
  int m_ch = 0, m_ptr = 0, m_issued = 0, m_returned = 0, m_base = 0;

  function automatic logic [ADDR_W-1:0] missAddr(input int ch);
    return miss_address[ch*ADDR_W +: ADDR_W];
  endfunction

  function automatic int rrPick();
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (m_ptr + k) % NUM_CH;
      if (miss_detected[c]) return c;
    end
    return -1;
  endfunction

  // Compare process: check this cycle's outputs, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_busy, exp_wda, exp_tag;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_rd, resp;
    int                pick;
    if (!rst_n) begin
      m_active = 0; m_tag = 0; m_ptr = 0; m_issued = 0; m_returned = 0; m_ch = 0;
      checkOutput("rst_read_en", 32'(memory_read_en), 0);
      checkOutput("rst_address", 32'(memory_address), 0);
      checkOutput("rst_wr_data", 32'(write_data_array), 0);
      checkOutput("rst_wr_tag", 32'(write_tag_array), 0);
      checkOutput("rst_busy", 32'(fsm_busy), 32'(miss_detected));
    end else begin
      pick = rrPick();
      exp_busy = miss_detected; exp_wda = '0; exp_tag = '0; exp_rd = 0; resp = 0; exp_addr = '0;
      if (m_tag) begin
        exp_busy[m_ch] = 1'b1; exp_tag[m_ch] = 1'b1;
      end else if (m_active) begin
        exp_busy[m_ch] = 1'b1;
        exp_rd   = m_issued < WPB;
        exp_addr = ADDR_W'(m_base + m_issued * WORD_BYTES);
        resp     = memory_data_valid && (m_returned < WPB);
        if (resp) exp_wda[m_ch] = 1'b1;
      end else if (pick >= 0) begin
        exp_addr = missAddr(pick);
      end
      checkOutput("read_en", 32'(memory_read_en), 32'(exp_rd));
      checkOutput("busy", 32'(fsm_busy), 32'(exp_busy));
      checkOutput("wr_data", 32'(write_data_array), 32'(exp_wda));
      checkOutput("wr_tag", 32'(write_tag_array), 32'(exp_tag));
      if (exp_rd || (!m_active && !m_tag)) checkOutput("address", 32'(memory_address), 32'(exp_addr));
      if (resp) checkOutput("offset", 32'(fill_word_offset), 32'(m_returned));
      if (m_tag) begin
        m_tag = 0;
      end else if (m_active) begin
        if (m_issued < WPB) m_issued++;
        if (resp) begin
          m_returned++;
          if (m_returned == WPB) begin m_active = 0; m_tag = 1; end
        end
      end else if (pick >= 0) begin
        m_ch = pick; m_base = int'(missAddr(pick)) & ~(BLK_BYTES - 1);
        m_active = 1; m_issued = 0; m_returned = 0; m_ptr = (pick + 1) % NUM_CH;
      end
    end
  end

  // Memory: returns one word per cycle, in order, lat_min..lat_max cycles after the read.
  int cyc = 0, lat_min = 1, lat_max = 3;
  bit spurious_en = 0;
  int due_q[$];
  initial forever begin
    @(negedge clk);
    if (!rst_n) due_q.delete();
    else if (memory_read_en) due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
    @(posedge clk); #1;
    cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      memory_data_valid = 1'b1;
      void'(due_q.pop_front());
    end else begin
      memory_data_valid = spurious_en && due_q.size() == 0 && !m_active && ($urandom_range(0, 3) == 0);
    end
  end

  // Observation logs for the hand-computed scenario checks.
  int rd_log[$], wr_off[$], tag_log[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (memory_read_en) rd_log.push_back(int'(memory_address));
      if (|write_data_array) wr_off.push_back(int'(fill_word_offset));
      for (int i = 0; i < NUM_CH; i++) if (write_tag_array[i]) tag_log.push_back(i);
    end
  end

  task automatic clearLogs();
    rd_log.delete(); wr_off.delete(); tag_log.delete();
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    miss_address  = {a1, a0};
    miss_detected = miss_detected | mask;
  endtask

  // Holds misses until their tag write is seen; optionally drops a miss once its data starts.
  task automatic waitService(input logic [NUM_CH-1:0] pend_in, input bit early_drop, input int stop_writes);
    logic [NUM_CH-1:0] pend, drop;
    int cycles, writes;
    pend = pend_in; drop = '0; cycles = 0; writes = 0;
    while (pend != 0) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        if (write_tag_array[i]) begin pend[i] = 1'b0; drop[i] = 1'b1; end
        if (write_data_array[i]) begin writes++; if (early_drop) drop[i] = 1'b1; end
      end
      if (stop_writes > 0 && writes >= stop_writes) return;
      @(posedge clk); #1;
      miss_detected = miss_detected & ~drop;
      cycles++;
      if (cycles > 400) begin
        checkOutput("service_timeout_pending", 32'(pend), 0);
        miss_detected = '0;
        return;
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_read_en", 32'(memory_read_en), 0);
    checkOutput("reset_address", 32'(memory_address), 0);
    checkOutput("reset_busy", 32'(fsm_busy), 0);
    rst_n = 1'b1;

    // Single miss on channel 0.
    clearLogs();
    applyStimulus(2'b01, 16'h1236, 16'h0000);
    waitService(2'b01, 0, 0);
    checkOutput("s1_reads", rd_log.size(), 8);
    for (int k = 0; k < 8 && k < rd_log.size(); k++) checkOutput("s1_read_addr", rd_log[k], 32'h1230 + 2 * k);
    checkOutput("s1_writes", wr_off.size(), 8);
    for (int k = 0; k < 8 && k < wr_off.size(); k++) checkOutput("s1_offset", wr_off[k], k);
    checkOutput("s1_tags", tag_log.size(), 1);
    if (tag_log.size() > 0) checkOutput("s1_tag_ch", tag_log[0], 0);

    // Both channels miss straight out of reset.
    doReset();
    spurious_en = 1;
    clearLogs();
    applyStimulus(2'b11, 16'h4000, 16'h8010);
    waitService(2'b11, 0, 0);
    checkOutput("s2_tags", tag_log.size(), 2);
    if (tag_log.size() == 2) begin
      checkOutput("s2_first", tag_log[0], 0);
      checkOutput("s2_second", tag_log[1], 1);
    end
    if (rd_log.size() > 8) checkOutput("s2_ch1_base", rd_log[8], 32'h8010);

    // Channel 1 alone, then both: channel 0 must win the second round.
    clearLogs();
    applyStimulus(2'b10, 16'h0000, 16'h0a0c);
    waitService(2'b10, 0, 0);
    applyStimulus(2'b11, 16'h3333, 16'h5555);
    waitService(2'b11, 0, 0);
    checkOutput("s3_tags", tag_log.size(), 3);
    if (tag_log.size() == 3) begin
      checkOutput("s3_first", tag_log[0], 1);
      checkOutput("s3_second", tag_log[1], 0);
      checkOutput("s3_third", tag_log[2], 1);
    end

    // Fixed four-cycle memory latency.
    lat_min = 4; lat_max = 4;
    clearLogs();
    applyStimulus(2'b01, 16'h2004, 16'h0000);
    waitService(2'b01, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("s4_reads", rd_log.size(), 8);
    checkOutput("s4_writes", wr_off.size(), 8);
    lat_min = 1; lat_max = 3;

    // Reset in the middle of a fill, then a clean refill.
    clearLogs();
    applyStimulus(2'b01, 16'h7778, 16'h0000);
    waitService(2'b01, 0, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_read_en", 32'(memory_read_en), 0);
    checkOutput("midrst_address", 32'(memory_address), 0);
    checkOutput("midrst_wr_data", 32'(write_data_array), 0);
    checkOutput("midrst_wr_tag", 32'(write_tag_array), 0);
    checkOutput("midrst_offset", 32'(fill_word_offset), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clearLogs();
    waitService(2'b01, 0, 0);
    checkOutput("refill_writes", wr_off.size(), 8);
    if (wr_off.size() > 0) checkOutput("refill_first_offset", wr_off[0], 0);
    if (rd_log.size() > 0) checkOutput("refill_first_addr", rd_log[0], 32'h7770);

    // Block at the top of the address space.
    clearLogs();
    applyStimulus(2'b10, 16'h0000, 16'hfffe);
    waitService(2'b10, 0, 0);
    checkOutput("top_reads", rd_log.size(), 8);
    if (rd_log.size() == 8) begin
      checkOutput("top_first", rd_log[0], 32'hfff0);
      checkOutput("top_last", rd_log[7], 32'hfffe);
    end

    // Randomized traffic, including misses dropped while their fill is running.
    for (int t = 0; t < 40; t++) begin
      logic [NUM_CH-1:0] mask;
      mask = NUM_CH'($urandom_range(1, 3));
      lat_min = $urandom_range(1, 3);
      lat_max = lat_min + $urandom_range(0, 3);
      applyStimulus(mask, ADDR_W'($urandom_range(0, 16'hffff)), ADDR_W'($urandom_range(0, 16'hffff)));
      waitService(mask, $urandom_range(0, 1) == 1, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-002 SHALL have parameter WORD_BYTES, default 2, meaning bytes per memory word (power of 2).
REQ-003 SHALL have parameter WORDS_PER_BLOCK, default 8, meaning words per cache block (power of 2, >=2).
REQ-004 SHALL have parameter NUM_CH, default 2, meaning number of requesting caches (e.g. I and D).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port miss_detected, input, NUM_CH, meaning per-channel miss request, level, held until serviced.
REQ-008 SHALL have port miss_address, input, NUM_CH*ADDR_W, meaning per-channel missing byte address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port memory_data_valid, input, 1, meaning one word returned this cycle, in request order.
REQ-010 SHALL have port memory_read_en, output, 1, meaning issue a read of memory_address this cycle.
REQ-011 SHALL have port memory_address, output, ADDR_W, meaning address of the word being requested.
REQ-012 SHALL have port fsm_busy, output, NUM_CH, meaning per-channel stall.
REQ-013 SHALL have port write_data_array, output, NUM_CH, meaning per-channel data-array write enable.
REQ-014 SHALL have port write_tag_array, output, NUM_CH, meaning per-channel tag-array write enable.
REQ-015 SHALL have port fill_word_offset, output, log2(WORDS_PER_BLOCK), meaning word index of the returning data.

Function
REQ-016 SHALL implement three states: IDLE, FILL, TAG.
REQ-017 SHALL, in IDLE with any miss_detected bit set, grant exactly one channel by round-robin and move to FILL next cycle.
REQ-018 SHALL give the round-robin pointer lowest-index priority after reset; after each grant, priority starts at grant+1 (mod NUM_CH).
REQ-019 SHALL latch the granted address block-aligned (low log2(WORDS_PER_BLOCK*WORD_BYTES) bits cleared) at the grant edge.
REQ-020 SHALL, in FILL, assert memory_read_en every cycle until WORDS_PER_BLOCK requests are issued; memory_address = base + req_count*WORD_BYTES.
REQ-021 SHALL count responses separately; on each memory_data_valid in FILL pulse write_data_array[grant] with fill_word_offset = resp_count, then increment it.
REQ-022 SHALL move FILL->TAG the cycle after the final response; TAG lasts one cycle with write_tag_array[grant]=1, then IDLE.
REQ-023 SHALL assert fsm_busy[i] combinationally when miss_detected[i]=1, or when state!=IDLE and grant==i.
REQ-024 SHALL ignore memory_data_valid outside FILL and after WORDS_PER_BLOCK responses.
REQ-025 SHALL ignore deassertion of miss_detected mid-fill; the fill completes.
REQ-026 SHALL, in IDLE, drive memory_read_en=0 and memory_address = miss_address of the highest-priority requester (0 if none).
REQ-027 SHALL wrap addresses modulo 2^ADDR_W (no carry out).

Reset
REQ-028 SHALL, asynchronously on rst_n=0 (including mid-fill), force IDLE, clear counters, grant and pointer; all registered outputs 0, memory_address 0.
REQ-029 SHALL begin arbitration on the first clock edge after rst_n rises.

Structure
REQ-030 SHALL place state encoding and offset-width function in shared package cache_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (NUM_CH, req, advance, grant one-hot).

Verification
REQ-032 SHALL test single miss ch0 at 0x1236 -> reads 0x1230..0x123E, 8 data writes offsets 0..7, one write_tag_array[0].
REQ-033 SHALL test simultaneous ch0/ch1 misses from reset -> ch0 served first, then ch1; fsm_busy[1]=1 throughout.
REQ-034 SHALL test back-to-back ch1 then both -> ch0 granted second (round-robin).
REQ-035 SHALL test valid 4-cycle pipelined latency -> exactly 8 requests, 8 writes, no extra read_en.
REQ-036 SHALL test rst_n low after 3 responses -> outputs 0 immediately; next miss refills from offset 0.
REQ-037 SHALL test miss at 0xFFFE -> block base 0xFFF0, last request 0xFFFE, no wrap error.
